// File: rtl/square_motion_pkg.sv
// ---------------------------------------------------------------------------
// square_motion_pkg
// Shared definitions for the square motion controller: FSM state encoding,
// reset colour, speed range and the small colour/speed sequencing helpers.
// ---------------------------------------------------------------------------
package square_motion_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    UPD_X = 2'd2,
    UPD_Y = 2'd3
  } state_e;

  localparam logic [2:0] COLOR_RESET = 3'b100;
  localparam logic [2:0] SPEED_MIN   = 3'd1;
  localparam logic [2:0] SPEED_MAX   = 3'd4;

  // Colour steps 1..7 and wraps to 1, so black (000) is never produced.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

  function automatic logic [2:0] next_speed(input logic [2:0] s);
    return (s == SPEED_MAX) ? SPEED_MIN : s + 3'd1;
  endfunction

endpackage

// File: rtl/square_motion_ctrl_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One key input: 2-FF synchroniser, optional debounce filter, rising-edge
// detect producing a single-cycle press pulse.
// Configuration macro: SQUARE_MOTION_DEBOUNCE_EN enables the debounce filter;
// when undefined the synchroniser output feeds the edge detect directly.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   key_in         raw asynchronous key level (active high)
//   press          one-cycle pulse on an accepted rising edge
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic press
);

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q;

  // NOTE: the reset is in the sensitivity list so the flops clear
  // asynchronously; all sequential state uses non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef SQUARE_MOTION_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The accepted level only follows the synchronised input after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles; any return to the
  // accepted level restarts the count.
  // NOTE: every signal written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign level = sync2_q;
`endif

  assign press = level & ~prev_q;

endmodule

// File: rtl/square_motion_ctrl.sv
// ---------------------------------------------------------------------------
// square_motion_ctrl
// Frame-synchronous position/colour controller for the VGA square renderer.
// Detects the start of vertical blanking, then steps X and Y (with edge
// bounce) once per frame and applies pending colour changes.
// Configuration macro: SQUARE_MOTION_DEBOUNCE_EN (key debounce filter).
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   key_sw[3:0]   [0] run/pause, [1] next colour, [2] next speed, [3] unused
//   display_on    visible-area flag (not used for sequencing)
//   hpos, vpos    current VGA pixel column / line
//   sq_x, sq_y    registered square top-left corner
//   sq_color      registered square RGB
//   frame_tick    one-cycle pulse at start of vertical blank
// ---------------------------------------------------------------------------
module square_motion_ctrl
  import square_motion_pkg::*;
#(
  parameter int HPOS_WIDTH      = 10,
  parameter int VPOS_WIDTH      = 10,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SQ_SIZE         = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            key_sw,
  input  logic                  display_on,
  input  logic [HPOS_WIDTH-1:0] hpos,
  input  logic [VPOS_WIDTH-1:0] vpos,
  output logic [HPOS_WIDTH-1:0] sq_x,
  output logic [VPOS_WIDTH-1:0] sq_y,
  output logic [2:0]            sq_color,
  output logic                  frame_tick
);

  localparam logic [HPOS_WIDTH-1:0] XMAX    = HPOS_WIDTH'(SCREEN_W - SQ_SIZE);
  localparam logic [VPOS_WIDTH-1:0] YMAX    = VPOS_WIDTH'(SCREEN_H - SQ_SIZE);
  localparam logic [VPOS_WIDTH-1:0] VB_LINE = VPOS_WIDTH'(SCREEN_H);

  logic unused_inputs;
  assign unused_inputs = display_on ^ key_sw[3];

  // Key command pulses
  logic press_run, press_color, press_speed;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
    .clk(clk), .reset(reset), .key_in(key_sw[0]), .press(press_run));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_color (
    .clk(clk), .reset(reset), .key_in(key_sw[1]), .press(press_color));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_speed (
    .clk(clk), .reset(reset), .key_in(key_sw[2]), .press(press_speed));

  // State
  state_e                state_q, state_d;
  logic [HPOS_WIDTH-1:0] x_q, x_d;
  logic [VPOS_WIDTH-1:0] y_q, y_d;
  logic                  dir_x_q, dir_x_d;   // 1 = moving +
  logic                  dir_y_q, dir_y_d;
  logic [2:0]            color_q, color_d;
  logic [2:0]            pend_color_q, pend_color_d;
  logic [2:0]            speed_q, speed_d;
  logic [2:0]            step_speed_q, step_speed_d; // speed frozen for this frame
  logic                  pause_pend_q, pause_pend_d;
  logic                  cond_q, cond_d;
  logic                  tick_q, tick_d;

  // Frame detect: tick only on the rising edge of cond, so a pixel held for
  // several cycles still yields one tick.
  assign cond_d = (hpos == '0) && (vpos == VB_LINE);
  assign tick_d = cond_d & ~cond_q;

  // Step arithmetic one bit wider than the coordinate so pos + s never wraps.
  logic [HPOS_WIDTH:0] x_sum;
  logic [VPOS_WIDTH:0] y_sum;
  assign x_sum = {1'b0, x_q} + (HPOS_WIDTH+1)'(speed_q);
  assign y_sum = {1'b0, y_q} + (VPOS_WIDTH+1)'(step_speed_q);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    color_d      = color_q;
    pend_color_d = press_color ? next_color(pend_color_q) : pend_color_q;
    speed_d      = press_speed ? next_speed(speed_q) : speed_q;
    step_speed_d = step_speed_q;
    pause_pend_d = pause_pend_q;

    unique case (state_q)
      PAUSE: begin
        if (tick_q)    color_d = pend_color_q;
        if (press_run) state_d = RUN;
      end
      RUN: begin
        if (tick_q) begin
          state_d      = UPD_X;
          pause_pend_d = press_run;
        end else if (press_run) begin
          state_d = PAUSE;
        end
      end
      UPD_X: begin
        step_speed_d = speed_q;
        if (dir_x_q) begin
          if (x_sum >= {1'b0, XMAX}) begin
            x_d     = XMAX;
            dir_x_d = 1'b0;
          end else begin
            x_d = x_sum[HPOS_WIDTH-1:0];
          end
        end else begin
          if (x_q <= HPOS_WIDTH'(speed_q)) begin
            x_d     = '0;
            dir_x_d = 1'b1;
          end else begin
            x_d = x_q - HPOS_WIDTH'(speed_q);
          end
        end
        if (press_run) pause_pend_d = 1'b1;
        state_d = UPD_Y;
      end
      UPD_Y: begin
        if (dir_y_q) begin
          if (y_sum >= {1'b0, YMAX}) begin
            y_d     = YMAX;
            dir_y_d = 1'b0;
          end else begin
            y_d = y_sum[VPOS_WIDTH-1:0];
          end
        end else begin
          if (y_q <= VPOS_WIDTH'(step_speed_q)) begin
            y_d     = '0;
            dir_y_d = 1'b1;
          end else begin
            y_d = y_q - VPOS_WIDTH'(step_speed_q);
          end
        end
        color_d      = pend_color_q;
        state_d      = (pause_pend_q || press_run) ? PAUSE : RUN;
        pause_pend_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      x_q          <= XMAX >> 1;
      y_q          <= YMAX >> 1;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      color_q      <= COLOR_RESET;
      pend_color_q <= COLOR_RESET;
      speed_q      <= SPEED_MIN;
      step_speed_q <= SPEED_MIN;
      pause_pend_q <= 1'b0;
      cond_q       <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      color_q      <= color_d;
      pend_color_q <= pend_color_d;
      speed_q      <= speed_d;
      step_speed_q <= step_speed_d;
      pause_pend_q <= pause_pend_d;
      cond_q       <= cond_d;
      tick_q       <= tick_d;
    end
  end

  assign sq_x       = x_q;
  assign sq_y       = y_q;
  assign sq_color   = color_q;
  assign frame_tick = tick_q;

endmodule
